// File: rtl/wb_la_mem_arbiter.sv
// Round-robin arbiter sharing the rift2 core bus port between the Caravel Wishbone slave and the LA debug port.
// Define WB_ARB_TIMEOUT_EN to add a downstream watchdog that completes stalled transactions with 32'hDEAD_BEEF.
module wb_la_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [DW/8-1:0] wbs_sel_i,
    input  logic [AW-1:0]   wbs_adr_i,
    input  logic [DW-1:0]   wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [DW-1:0]   wbs_dat_o,
    input  logic            la_req_i,
    input  logic            la_we_i,
    input  logic [AW-1:0]   la_adr_i,
    input  logic [DW-1:0]   la_wdat_i,
    output logic            la_done_o,
    output logic [DW-1:0]   la_rdat_o,
    output logic            m_req_o,
    output logic            m_we_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_wdat_o,
    input  logic            m_gnt_i,
    input  logic            m_rvalid_i,
    input  logic [DW-1:0]   m_rdata_i,
    output logic            busy_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t          state_q, state_d;
    logic            owner_q, owner_d;   // 0 = Wishbone, 1 = LA
    logic            last_q, last_d;
    logic            abort_q, abort_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [DW/8-1:0] sel_q, sel_d;
    logic [DW-1:0]   wb_rdat_q, wb_rdat_d;
    logic [DW-1:0]   la_rdat_q, la_rdat_d;
    logic            timeout_q, timeout_d;
    logic            wb_pend, la_pend, grant_la, in_flight;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign wb_pend   = wbs_cyc_i & wbs_stb_i;
    assign la_pend   = la_req_i;
    // With both pending, the requester that did not win last time takes the port.
    assign grant_la  = la_pend & (~wb_pend | ~last_q);
    assign in_flight = (state_q == REQ) || (state_q == RESP);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        abort_d   = abort_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        wb_rdat_d = wb_rdat_q;
        la_rdat_d = la_rdat_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (wb_pend || la_pend) begin
                    owner_d = grant_la;
                    last_d  = grant_la;
                    abort_d = 1'b0;
                    we_d    = grant_la ? la_we_i   : wbs_we_i;
                    adr_d   = grant_la ? la_adr_i  : wbs_adr_i;
                    wdat_d  = grant_la ? la_wdat_i : wbs_dat_i;
                    sel_d   = grant_la ? {(DW/8){1'b1}} : wbs_sel_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (m_gnt_i) state_d = RESP;
            end
            RESP: begin
                if (m_rvalid_i) begin
                    if (owner_q) la_rdat_d = m_rdata_i;
                    else         wb_rdat_d = m_rdata_i;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A Wishbone master that abandons its cycle still lets the core access finish, but gets no ack.
        if (in_flight && !owner_q && !wbs_cyc_i) abort_d = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (in_flight) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(TIMEOUT) && !(state_q == RESP && m_rvalid_i)) begin
                state_d   = DONE;
                timeout_d = 1'b1;
                if (owner_q) la_rdat_d = DW'(32'hDEAD_BEEF);
                else         wb_rdat_d = DW'(32'hDEAD_BEEF);
            end
        end
`endif
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            abort_q   <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            wb_rdat_q <= '0;
            la_rdat_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            abort_q   <= abort_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            wb_rdat_q <= wb_rdat_d;
            la_rdat_q <= la_rdat_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign m_req_o   = (state_q == REQ);
    assign m_we_o    = we_q;
    assign m_sel_o   = sel_q;
    assign m_adr_o   = adr_q;
    assign m_wdat_o  = wdat_q;
    assign wbs_ack_o = (state_q == DONE) & ~owner_q & ~abort_q;
    assign la_done_o = (state_q == DONE) & owner_q;
    assign wbs_dat_o = wb_rdat_q;
    assign la_rdat_o = la_rdat_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/wb_la_mem_arbiter.md
Name: wb_la_mem_arbiter

Overview:
Shares the rift2 core's single internal register/memory access port between two requesters: the Caravel Wishbone slave (management SoC) and a logic-analyzer-driven debug port. It arbitrates round-robin, sequences one outstanding transaction at a time through a request/grant/response handshake, and returns the data and acknowledge to the winning requester. It sits inside rift2Wrap, between the wrapper pins and the core's bus port.

Parameters:
AW, 32, address width of all ports
DW, 32, data width of all ports
TIMEOUT, 255, downstream wait limit in cycles (used only with WB_ARB_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_ni  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  DW/8  Wishbone byte selects
wbs_adr_i  in  AW  Wishbone address
wbs_dat_i  in  DW  Wishbone write data
wbs_ack_o  out  1  Wishbone acknowledge, 1-cycle pulse
wbs_dat_o  out  DW  Wishbone read data
la_req_i  in  1  debug request, level
la_we_i  in  1  debug write enable
la_adr_i  in  AW  debug address
la_wdat_i  in  DW  debug write data
la_done_o  out  1  debug completion, 1-cycle pulse
la_rdat_o  out  DW  debug read data
m_req_o  out  1  downstream request
m_we_o  out  1  downstream write enable
m_sel_o  out  DW/8  downstream byte selects
m_adr_o  out  AW  downstream address
m_wdat_o  out  DW  downstream write data
m_gnt_i  in  1  downstream accepts the request
m_rvalid_i  in  1  downstream response (reads and writes)
m_rdata_i  in  DW  downstream read data
busy_o  out  1  state is not IDLE
timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0. State is IDLE. The last-grant pointer points to LA, so WB wins first.
- Pending requests:
  - WB is pending when wbs_cyc_i & wbs_stb_i in IDLE.
  - LA is pending when la_req_i in IDLE.
- IDLE:
  - If only one requester is pending, grant it.
  - If both are pending, grant the one not granted last.
  - On grant, register the owner bit, we, adr, wdat and sel. LA always uses sel = all ones.
  - Update the pointer and go to REQ.
- REQ:
  - m_req_o = 1, with the m_* fields driven from registers.
  - m_gnt_i = 1 moves to RESP. m_req_o drops the next cycle.
  - m_rvalid_i is ignored in REQ.
- RESP:
  - m_rvalid_i = 1 latches m_rdata_i into the owner's read-data register (write responses latch it too) and moves to DONE.
- DONE:
  - Pulse wbs_ack_o if the owner is WB, or la_done_o if the owner is LA, for exactly one cycle.
  - Return to IDLE.
  - The non-owner's read data holds its old value.
- Latency: stb seen at cycle 0, gnt at cycle 1, rvalid at cycle 2 gives ack at cycle 3. A new request is arbitrated at cycle 4 at the earliest. Throughput is one transaction per 4 cycles.
- WB abort: if wbs_cyc_i drops while WB owns REQ or RESP, the downstream transaction still completes. The ack is suppressed, and wbs_dat_o is still updated.
- LA must drop la_req_i after la_done_o. A level held in IDLE is a new request.
- Back-to-back with both pending: grants alternate WB, LA, WB, ...
- wbs_dat_o and la_rdat_o hold their values between responses.
- Asynchronous reset mid-transaction clears everything immediately. No ack is issued afterwards.

Optional Feature:
WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments in REQ and RESP.
  - When it reaches TIMEOUT, the block goes to DONE, forces the owner's read data to 32'hDEAD_BEEF, and acks normally.
  - m_req_o drops and timeout_o sets; it is sticky until reset.
  - A late m_rvalid_i is ignored.
- Undefined: no counter. The block waits indefinitely and timeout_o is tied to 0.

Test Plan:
- WB read, adr 0x3000_0004, gnt at cycle 1, rvalid at cycle 2 with data 0x1234_5678 -> m_adr_o = 0x3000_0004 and m_sel_o = 4'hF at cycle 1; wbs_ack_o at cycle 3 only; wbs_dat_o = 0x1234_5678; la_done_o stays 0.
- LA write, adr 0x10, wdat 0xA5A5_A5A5, gnt delayed 5 cycles -> m_req_o held high 5 cycles with stable fields, m_we_o = 1, m_sel_o = 4'hF; la_done_o one pulse after rvalid.
- WB and LA both requesting continuously from reset, 4 transactions -> grant order WB, LA, WB, LA; each ack/done pulse is exactly 1 cycle.
- WB drops cyc during RESP, rvalid data 0xCAFE_0001 -> no wbs_ack_o; wbs_dat_o = 0xCAFE_0001; next LA request is granted normally.
- With WB_ARB_TIMEOUT_EN and TIMEOUT = 16, gnt given but no rvalid -> ack 16 cycles after REQ entry; wbs_dat_o = 0xDEAD_BEEF; timeout_o = 1 until reset.
- wb_rst_ni asserted in RESP -> all outputs 0 immediately; the rvalid that follows is ignored and no ack appears.
